// File: rtl/river_pkg.sv
// Shared definitions for the river crossing game: state and move encodings,
// bank bit positions, and helpers that decode a move request.
package river_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_WON  = 2'b01,
    ST_LOST = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SEL_FARMER  = 2'd0,
    SEL_CABBAGE = 2'd1,
    SEL_GOAT    = 2'd2,
    SEL_WOLF    = 2'd3
  } move_sel_e;

  localparam int FARMER  = 3;
  localparam int CABBAGE = 2;
  localparam int GOAT    = 1;
  localparam int WOLF    = 0;

  // Bits that flip when the move is carried out; the farmer always rows.
  function automatic logic [3:0] move_mask(input logic [1:0] sel);
    logic [3:0] mask;
    mask = '0;
    mask[FARMER] = 1'b1;
    case (move_sel_e'(sel))
      SEL_CABBAGE: mask[CABBAGE] = 1'b1;
      SEL_GOAT:    mask[GOAT]    = 1'b1;
      SEL_WOLF:    mask[WOLF]    = 1'b1;
      default:     ;
    endcase
    return mask;
  endfunction

  function automatic logic move_legal(input logic [3:0] pos, input logic [1:0] sel);
    logic legal;
    case (move_sel_e'(sel))
      SEL_CABBAGE: legal = (pos[CABBAGE] == pos[FARMER]);
      SEL_GOAT:    legal = (pos[GOAT]    == pos[FARMER]);
      SEL_WOLF:    legal = (pos[WOLF]    == pos[FARMER]);
      default:     legal = 1'b1;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/crossing_safety_check.sv
// Combinational safety/win evaluation of a 4-bit {farmer,cabbage,goat,wolf}
// position; shared between the game core and the display logic.
module crossing_safety_check
  import river_pkg::*;
(
  input  logic [3:0] pos_i,
  output logic       unsafe_o,
  output logic       all_across_o
);

  assign unsafe_o = ((pos_i[GOAT] == pos_i[CABBAGE]) && (pos_i[GOAT] != pos_i[FARMER])) ||
                    ((pos_i[GOAT] == pos_i[WOLF])    && (pos_i[GOAT] != pos_i[FARMER]));

  assign all_across_o = &pos_i;

endmodule

// File: rtl/river_crossing_game.sv
// Registered river crossing game: one move per handshake, legality, safety,
// win and move-limit tracking. Define RIVER_UNDO_EN for one-deep undo support.
module river_crossing_game
  import river_pkg::*;
#(
  parameter int MAX_MOVES = 15,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             move_valid,
  input  logic [1:0]       move_sel,
  input  logic             restart,
`ifdef RIVER_UNDO_EN
  input  logic             undo,
  output logic             undo_avail,
`endif
  output logic             move_ready,
  output logic [3:0]       pos,
  output logic             alarm,
  output logic [1:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] move_cnt
);

  state_e           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic             move_fire;
  logic             move_ok;
  logic [3:0]       moved_pos;
  logic [3:0]       eval_pos;
  logic [CNT_W-1:0] cnt_inc;
  logic             eval_unsafe;
  logic             eval_won;

  assign move_fire = move_valid && (state_q == ST_PLAY);
  assign move_ok   = move_legal(pos_q, move_sel);
  assign moved_pos = pos_q ^ move_mask(move_sel);
  assign cnt_inc   = cnt_q + CNT_W'(1);

`ifdef RIVER_UNDO_EN
  logic [3:0]       hist_pos_q, hist_pos_d;
  logic [CNT_W-1:0] hist_cnt_q, hist_cnt_d;
  logic             hist_vld_q, hist_vld_d;
  logic             undo_fire;

  // A timeout loss is final; only a loss caused by an unsafe bank can be undone.
  assign undo_fire  = undo && hist_vld_q &&
                      ((state_q == ST_PLAY) || ((state_q == ST_LOST) && !timeout_q));
  assign eval_pos   = undo_fire ? hist_pos_q : moved_pos;
  assign undo_avail = hist_vld_q;
`else
  assign eval_pos = moved_pos;
`endif

  crossing_safety_check u_safety (
    .pos_i        (eval_pos),
    .unsafe_o     (eval_unsafe),
    .all_across_o (eval_won)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    alarm_d   = alarm_q;
    illegal_d = 1'b0;
    timeout_d = timeout_q;
`ifdef RIVER_UNDO_EN
    hist_pos_d = hist_pos_q;
    hist_cnt_d = hist_cnt_q;
    hist_vld_d = hist_vld_q;
`endif
    if (restart) begin
      state_d   = ST_PLAY;
      pos_d     = '0;
      cnt_d     = '0;
      alarm_d   = 1'b0;
      timeout_d = 1'b0;
`ifdef RIVER_UNDO_EN
      hist_vld_d = 1'b0;
`endif
    end
`ifdef RIVER_UNDO_EN
    else if (undo_fire) begin
      state_d    = ST_PLAY;
      pos_d      = hist_pos_q;
      cnt_d      = hist_cnt_q;
      alarm_d    = eval_unsafe;
      timeout_d  = 1'b0;
      hist_vld_d = 1'b0;
    end
`endif
    else if (move_fire) begin
      if (move_ok) begin
        pos_d   = moved_pos;
        cnt_d   = cnt_inc;
        alarm_d = eval_unsafe;
`ifdef RIVER_UNDO_EN
        hist_pos_d = pos_q;
        hist_cnt_d = cnt_q;
        hist_vld_d = 1'b1;
`endif
        // Win beats an unsafe bank, which beats running out of moves.
        if (eval_won) begin
          state_d = ST_WON;
        end else if (eval_unsafe) begin
          state_d   = ST_LOST;
          timeout_d = 1'b0;
        end else if (cnt_inc == CNT_W'(MAX_MOVES)) begin
          state_d   = ST_LOST;
          timeout_d = 1'b1;
        end
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLAY;
      pos_q     <= '0;
      cnt_q     <= '0;
      alarm_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef RIVER_UNDO_EN
      hist_pos_q <= '0;
      hist_cnt_q <= '0;
      hist_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      alarm_q   <= alarm_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
`ifdef RIVER_UNDO_EN
      hist_pos_q <= hist_pos_d;
      hist_cnt_q <= hist_cnt_d;
      hist_vld_q <= hist_vld_d;
`endif
    end
  end

  assign move_ready = (state_q == ST_PLAY);
  assign pos        = pos_q;
  assign alarm      = alarm_q;
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;
  assign move_cnt   = cnt_q;

endmodule

// File: tb/tb_river_crossing_game.sv
// Scoreboard bench for river_crossing_game: dutA uses the default move limit,
// dutB a limit of 4; both share stimulus, each expectation names its DUT.
module tb_river_crossing_game;
  import river_pkg::*;

  typedef struct {
    bit         dut;
    logic [3:0] pos;
    logic [1:0] st;
    logic       al;
    logic       il;
    logic       to;
    logic [3:0] cnt;
    logic       rdy;
    logic       ua;
    int         due;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       mv;
  logic [1:0] sel;
  logic       rs;

  logic       aRdy, aAl, aIl, aTo;
  logic [3:0] aPos, aCnt;
  logic [1:0] aSt;
  logic       bRdy, bAl, bIl, bTo;
  logic [3:0] bPos, bCnt;
  logic [1:0] bSt;

`ifdef RIVER_UNDO_EN
  logic undoReq;
  bit   undoNext;
  logic aUa, bUa;
`endif

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] solSel[7];
  logic [3:0] solPos[7];

  river_crossing_game #(.MAX_MOVES(15), .CNT_W(4)) dutA (
    .clk        (clk),
    .rst_n      (rst_n),
    .move_valid (mv),
    .move_sel   (sel),
    .restart    (rs),
`ifdef RIVER_UNDO_EN
    .undo       (undoReq),
    .undo_avail (aUa),
`endif
    .move_ready (aRdy),
    .pos        (aPos),
    .alarm      (aAl),
    .state      (aSt),
    .illegal    (aIl),
    .timeout    (aTo),
    .move_cnt   (aCnt)
  );

  river_crossing_game #(.MAX_MOVES(4), .CNT_W(4)) dutB (
    .clk        (clk),
    .rst_n      (rst_n),
    .move_valid (mv),
    .move_sel   (sel),
    .restart    (rs),
`ifdef RIVER_UNDO_EN
    .undo       (undoReq),
    .undo_avail (bUa),
`endif
    .move_ready (bRdy),
    .pos        (bPos),
    .alarm      (bAl),
    .state      (bSt),
    .illegal    (bIl),
    .timeout    (bTo),
    .move_cnt   (bCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExp(input bit d, input string nm, input logic [3:0] ePos,
                         input logic [1:0] eSt, input logic eAl, input logic eIl,
                         input logic eTo, input int eCnt, input logic eUa, input int due);
    exp_t e;
    e.dut  = d;
    e.name = nm;
    e.pos  = ePos;
    e.st   = eSt;
    e.al   = eAl;
    e.il   = eIl;
    e.to   = eTo;
    e.cnt  = 4'(eCnt);
    e.rdy  = (eSt == ST_PLAY);
    e.ua   = eUa;
    e.due  = due;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs; the registered result is due one edge later.
  task automatic applyStimulus(input bit d, input logic v, input logic [1:0] s, input logic r,
                               input string nm, input logic [3:0] ePos, input logic [1:0] eSt,
                               input logic eAl, input logic eIl, input logic eTo,
                               input int eCnt, input logic eUa);
    @(negedge clk);
    #1;
    mv  = v;
    sel = s;
    rs  = r;
`ifdef RIVER_UNDO_EN
    undoReq = undoNext;
`endif
    pushExp(d, nm, ePos, eSt, eAl, eIl, eTo, eCnt, eUa, cyc + 1);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [14:0] got, want;
    logic        gotUa, wantUa;
    gotUa  = 1'b0;
    wantUa = 1'b0;
`ifdef RIVER_UNDO_EN
    gotUa  = e.dut ? bUa : aUa;
    wantUa = e.ua;
`endif
    if (e.dut) got = {bPos, bSt, bAl, bIl, bTo, bCnt, bRdy, gotUa};
    else       got = {aPos, aSt, aAl, aIl, aTo, aCnt, aRdy, gotUa};
    want = {e.pos, e.st, e.al, e.il, e.to, e.cnt, e.rdy, wantUa};
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s dut%0d: got pos=%b st=%b alarm=%b illegal=%b timeout=%b cnt=%0d ready=%b ua=%b, expected pos=%b st=%b alarm=%b illegal=%b timeout=%b cnt=%0d ready=%b ua=%b",
               e.name, e.dut, got[14:11], got[10:9], got[8], got[7], got[6], got[5:2], got[1], got[0],
               e.pos, e.st, e.al, e.il, e.to, e.cnt, e.rdy, wantUa);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due <= cyc) checkOutput(q.pop_front());
  end

  // Reset asserted between edges must clear outputs before the next edge,
  // and a move presented while reset is low must never land.
  task automatic asyncResetCheck();
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pushExp(0, "async-clear", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0, cyc);
    @(negedge clk);
    #1;
    mv  = 1'b1;
    sel = 2'd0;
    pushExp(0, "async-inflight", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0, cyc + 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mv    = 1'b0;
    pushExp(0, "async-release", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0, cyc + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    mv    = 1'b0;
    sel   = 2'd0;
    rs    = 1'b0;
`ifdef RIVER_UNDO_EN
    undoReq  = 1'b0;
    undoNext = 1'b0;
`endif
    solSel = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
    solPos = '{4'b1010, 4'b0010, 4'b1011, 4'b0001, 4'b1101, 4'b0101, 4'b1111};

    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, "reset", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++)
      applyStimulus(0, 1, solSel[i], 0, "solution", solPos[i], (i == 6) ? ST_WON : ST_PLAY,
                    0, 0, 0, i + 1, 1);
    applyStimulus(0, 1, 2'd0, 0, "won-hold", 4'b1111, ST_WON, 0, 0, 0, 7, 1);
    applyStimulus(0, 0, 0, 1, "restart-won", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 2'd1, 0, "cabbage-lost", 4'b1100, ST_LOST, 1, 0, 0, 1, 1);
    applyStimulus(0, 1, 2'd0, 0, "lost-hold", 4'b1100, ST_LOST, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, "restart-lost", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 2'd2, 0, "goat", 4'b1010, ST_PLAY, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 2'd1, 0, "illegal", 4'b1010, ST_PLAY, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, "illegal-clear", 4'b1010, ST_PLAY, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 2'd2, 1, "restart-beats-move", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);

    for (int i = 1; i <= 4; i++)
      applyStimulus(1, 1, 2'd2, 0, "b-limit", (i % 2 == 1) ? 4'b1010 : 4'b0000,
                    (i == 4) ? ST_LOST : ST_PLAY, 0, 0, (i == 4), i, 1);
    applyStimulus(0, 0, 0, 1, "restart-b", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);

    for (int i = 1; i <= 15; i++)
      applyStimulus(0, 1, 2'd2, 0, "a-limit", (i % 2 == 1) ? 4'b1010 : 4'b0000,
                    (i == 15) ? ST_LOST : ST_PLAY, 0, 0, (i == 15), i, 1);
    applyStimulus(0, 1, 2'd0, 0, "limit-hold", 4'b1010, ST_LOST, 0, 0, 1, 15, 1);
    applyStimulus(0, 0, 0, 1, "restart-a", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 2'd2, 0, "pre-reset", 4'b1010, ST_PLAY, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, "pre-reset-idle", 4'b1010, ST_PLAY, 0, 0, 0, 1, 1);
    asyncResetCheck();

`ifdef RIVER_UNDO_EN
    applyStimulus(0, 1, 2'd1, 0, "u-cabbage", 4'b1100, ST_LOST, 1, 0, 0, 1, 1);
    undoNext = 1'b1;
    applyStimulus(0, 0, 0, 0, "undo-lost", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, "undo-again", 4'b0000, ST_PLAY, 0, 0, 0, 0, 0);
    undoNext = 1'b0;
    applyStimulus(0, 1, 2'd2, 0, "u-goat", 4'b1010, ST_PLAY, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 2'd0, 0, "u-farmer", 4'b0010, ST_PLAY, 0, 0, 0, 2, 1);
    undoNext = 1'b1;
    applyStimulus(0, 0, 0, 0, "undo-play", 4'b1010, ST_PLAY, 0, 0, 0, 1, 0);
    undoNext = 1'b0;
    applyStimulus(0, 0, 0, 0, "undo-idle", 4'b1010, ST_PLAY, 0, 0, 0, 1, 0);
`endif

    repeat (4) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
